imem_load_ctrl: RTL and testbench

Sequencer and port arbiter for the single-port instruction memory (prgrom) behind the fetch stage. It decides whether the UART programmer or the CPU fetch path owns the memory port, counts loaded words and flags bad writes. It also holds the CPU in reset while loading and for a short settle window afterwards, then releases it with `cpu_inited`. It replaces the ad-hoc kickOff/inited gating at the fetch unit.

---
 rtl/imem_load_ctrl.sv | 170 +++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// imem_load_ctrl : instruction-memory port arbiter, load sequencer, CPU reset
// Rev 1.0
// ============================================================================
module imem_load_ctrl #(
   parameter int ADDR_W      = 14,
   parameter int FLUSH_CYC   = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pgm_req,
   input  logic              run_req,
   input  logic              upg_wen_i,
   input  logic [14:0]       upg_adr_i,
   input  logic [31:0]       upg_dat_i,
   input  logic              upg_done_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              cpu_rst,
   output logic              cpu_inited,
   output logic              loading,
   output logic [ADDR_W:0]   word_cnt,
   output logic              load_err
);

   localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
   localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W:0]    CNT_MAX    = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]         mem_din_q, mem_din_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                cpu_inited_q, cpu_inited_d;
   logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
   logic                load_err_q, load_err_d;
   logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic                wr_ok;

   assign wr_ok = upg_wen_i && !upg_adr_i[14];

   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      mem_din_d   = mem_din_q;
      word_cnt_d  = word_cnt_q;
      load_err_d  = load_err_q;
      flush_cnt_d = '0;
      tmo_cnt_d   = '0;

      case (state_q)
         ST_IDLE: begin
            if (pgm_req) begin
               state_d    = ST_LOAD;
               word_cnt_d = '0;
               load_err_d = 1'b0;
            end else if (run_req) begin
               state_d = ST_FLUSH;
            end
         end

         ST_LOAD: begin
            if (wr_ok) begin
               mem_we_d  = 1'b1;
               wr_addr_d = upg_adr_i[ADDR_W-1:0];
               mem_din_d = upg_dat_i;
               if (word_cnt_q != CNT_MAX)
                  word_cnt_d = word_cnt_q + 1'b1;
            end else if (upg_wen_i) begin
               load_err_d = 1'b1;
            end

            if (!upg_wen_i)
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

            // done wins over timeout; a write in the done cycle is still taken
            if (upg_done_i) begin
               state_d = ST_FLUSH;
            end else if (!upg_wen_i && (tmo_cnt_q == TMO_LAST)) begin
               state_d    = ST_IDLE;
               load_err_d = 1'b1;
            end
         end

         ST_FLUSH: begin
            if (pgm_req) begin
               state_d    = ST_LOAD;
               word_cnt_d = '0;
               load_err_d = 1'b0;
            end else if (flush_cnt_q == FLUSH_LAST) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
         end

         ST_RUN: begin
            if (pgm_req) begin
               state_d    = ST_LOAD;
               word_cnt_d = '0;
               load_err_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      cpu_rst_d    = (state_d != ST_RUN);
      cpu_inited_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         mem_we_q     <= 1'b0;
         wr_addr_q    <= '0;
         mem_din_q    <= '0;
         cpu_rst_q    <= 1'b1;
         cpu_inited_q <= 1'b0;
         word_cnt_q   <= '0;
         load_err_q   <= 1'b0;
         flush_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         mem_we_q     <= mem_we_d;
         wr_addr_q    <= wr_addr_d;
         mem_din_q    <= mem_din_d;
         cpu_rst_q    <= cpu_rst_d;
         cpu_inited_q <= cpu_inited_d;
         word_cnt_q   <= word_cnt_d;
         load_err_q   <= load_err_d;
         flush_cnt_q  <= flush_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   // Fetch path owns the address whenever no programmer write is in flight
   always_comb begin
      mem_addr = wr_addr_q;
      if (!mem_we_q && ((state_q == ST_FLUSH) || (state_q == ST_RUN)))
         mem_addr = fetch_addr_i;
   end

   assign mem_we     = mem_we_q;
   assign mem_din    = mem_din_q;
   assign cpu_rst    = cpu_rst_q;
   assign cpu_inited = cpu_inited_q;
   assign loading    = (state_q == ST_LOAD);
   assign word_cnt   = word_cnt_q;
   assign load_err   = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// tb_imem_load_ctrl : directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the load/flush/run sequencing.
module tb_imem_load_ctrl;

   localparam int AW = 14;
   localparam int FC = 4;
   localparam int TC = 16;

   localparam int MI = 0;
   localparam int ML = 1;
   localparam int MF = 2;
   localparam int MR = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          pgm_req, run_req, upg_wen_i, upg_done_i;
   logic [14:0]   upg_adr_i;
   logic [31:0]   upg_dat_i;
   logic [AW-1:0] fetch_addr_i;
   logic          mem_we, cpu_rst, cpu_inited, loading, load_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic [AW:0]   word_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_mode, m_flush_left, m_quiet, m_cnt, m_waddr;
   bit          m_err, m_we;
   logic [31:0] m_wdat;

   always #5 clk = ~clk;

   imem_load_ctrl #(.ADDR_W(AW), .FLUSH_CYC(FC), .TIMEOUT_CYC(TC)) dut (
      .clk(clk), .reset(reset), .pgm_req(pgm_req), .run_req(run_req),
      .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
      .upg_done_i(upg_done_i), .fetch_addr_i(fetch_addr_i),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .cpu_rst(cpu_rst), .cpu_inited(cpu_inited), .loading(loading),
      .word_cnt(word_cnt), .load_err(load_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = MI; m_flush_left = 0; m_quiet = 0; m_cnt = 0;
      m_waddr = 0; m_err = 1'b0; m_we = 1'b0; m_wdat = '0;
   endfunction

   function automatic void enter_load();
      m_mode = ML; m_cnt = 0; m_err = 1'b0; m_quiet = 0;
   endfunction

   function automatic void enter_flush();
      m_mode = MF; m_flush_left = FC;
   endfunction

   // One clock edge of the reference behaviour, using the inputs seen at that edge
   function automatic void model_update();
      m_we = 1'b0;
      case (m_mode)
         MI: if (pgm_req) enter_load(); else if (run_req) enter_flush();
         ML: begin
            if (upg_wen_i && !upg_adr_i[14]) begin
               m_we = 1'b1;
               m_waddr = int'(upg_adr_i[13:0]);
               m_wdat = upg_dat_i;
               if (m_cnt < (1 << AW)) m_cnt++;
            end else if (upg_wen_i) begin
               m_err = 1'b1;
            end
            m_quiet = upg_wen_i ? 0 : m_quiet + 1;
            if (upg_done_i) enter_flush();
            else if (m_quiet >= TC) begin m_mode = MI; m_err = 1'b1; end
         end
         MF: begin
            if (pgm_req) enter_load();
            else begin
               m_flush_left--;
               if (m_flush_left == 0) m_mode = MR;
            end
         end
         default: if (pgm_req) enter_load();
      endcase
   endfunction

   task automatic check_all();
      check_eq("mem_we", mem_we, m_we);
      if (m_we) begin
         check_eq("mem_addr_wr", mem_addr, m_waddr);
         check_eq("mem_din", mem_din, m_wdat);
      end else if (m_mode == MF || m_mode == MR) begin
         check_eq("mem_addr_fetch", mem_addr, fetch_addr_i);
      end
      check_eq("cpu_rst", cpu_rst, (m_mode != MR));
      check_eq("cpu_inited", cpu_inited, (m_mode == MR));
      check_eq("loading", loading, (m_mode == ML));
      check_eq("word_cnt", word_cnt, m_cnt);
      check_eq("load_err", load_err, m_err);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic cyc(input bit p, input bit r, input bit w, input logic [14:0] a,
                      input logic [31:0] d, input bit dn);
      pgm_req = p; run_req = r; upg_wen_i = w; upg_adr_i = a; upg_dat_i = d; upg_done_i = dn;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0);
   endtask

   task automatic apply_reset();
      #2;
      reset = 1'b1;
      pgm_req = 0; run_req = 0; upg_wen_i = 0; upg_adr_i = '0; upg_dat_i = '0; upg_done_i = 0;
      #1;
      model_reset();
      check_all();
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_din", mem_din, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pgm_req = 0; run_req = 0; upg_wen_i = 0; upg_adr_i = '0; upg_dat_i = '0; upg_done_i = 0;
      fetch_addr_i = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_din", mem_din, 0);
      reset = 1'b0;

      // Idle after reset: CPU held, no writes
      idle(10);
      check_eq("idle_cpu_rst", cpu_rst, 1);

      // Three-word load, done on the cycle after the last write
      fetch_addr_i = 14'h0040;
      cyc(1, 0, 0, '0, '0, 0);
      cyc(0, 0, 1, 15'd0, 32'h20080005, 0);
      check_eq("wr0_addr", mem_addr, 0);
      check_eq("wr0_din", mem_din, 32'h20080005);
      cyc(0, 0, 1, 15'd1, 32'h20090003, 0);
      check_eq("wr1_din", mem_din, 32'h20090003);
      cyc(0, 0, 1, 15'd2, 32'h01095020, 0);
      check_eq("wr2_addr", mem_addr, 2);
      cyc(0, 0, 0, '0, '0, 1);
      check_eq("load_word_cnt", word_cnt, 3);
      check_eq("flush_no_we", mem_we, 0);
      for (int i = 1; i < FC; i++) begin
         idle(1);
         check_eq("flush_hold", cpu_inited, 0);
      end
      idle(1);
      check_eq("run_after_flush", cpu_inited, 1);

      // In RUN: combinational fetch path, then pgm_req flips on next edge
      fetch_addr_i = 14'h0123;
      #1;
      check_eq("run_fetch_comb", mem_addr, 14'h0123);
      cyc(1, 1, 0, '0, '0, 0);
      check_eq("pgm_from_run_inited", cpu_inited, 0);
      check_eq("pgm_from_run_loading", loading, 1);

      // Out-of-range write then done
      cyc(0, 0, 1, 15'h4010, 32'hdeadbeef, 0);
      check_eq("oor_no_we", mem_we, 0);
      check_eq("oor_err", load_err, 1);
      check_eq("oor_cnt", word_cnt, 0);
      cyc(0, 0, 0, '0, '0, 1);
      idle(FC);
      check_eq("oor_reaches_run", cpu_inited, 1);

      // Timeout with no writes
      cyc(1, 0, 0, '0, '0, 0);
      idle(TC - 1);
      check_eq("tmo_still_load", loading, 1);
      idle(1);
      check_eq("tmo_idle", loading, 0);
      check_eq("tmo_err", load_err, 1);
      check_eq("tmo_cpu_rst", cpu_rst, 1);

      // Write and done together: write lands, then FLUSH
      cyc(1, 0, 0, '0, '0, 0);
      cyc(0, 0, 1, 15'h0007, 32'h12345678, 1);
      check_eq("wd_we", mem_we, 1);
      check_eq("wd_addr", mem_addr, 7);
      check_eq("wd_loading", loading, 0);
      idle(2);

      // Reset in the middle of a load
      cyc(1, 0, 0, '0, '0, 0);
      idle(FC + 1);
      cyc(1, 0, 0, '0, '0, 0);
      cyc(0, 0, 1, 15'h0010, 32'haaaa5555, 0);
      cyc(0, 0, 1, 15'h0011, 32'h5555aaaa, 0);
      apply_reset();
      check_eq("mid_rst_cnt", word_cnt, 0);
      check_eq("mid_rst_we", mem_we, 0);
      cyc(0, 1, 0, '0, '0, 0);
      idle(FC - 1);
      check_eq("run_req_hold", cpu_inited, 0);
      idle(1);
      check_eq("run_req_run", cpu_inited, 1);

      // Randomized traffic in episodes with varying write density
      for (int ep = 0; ep < 60; ep++) begin
         int wen_lvl;
         wen_lvl = $urandom_range(0, 3);
         for (int c = 0; c < 50; c++) begin
            logic [14:0] a;
            if ($urandom_range(0, 399) == 0) begin
               apply_reset();
            end else begin
               a = 15'($urandom);
               a[14] = ($urandom_range(0, 7) == 0);
               fetch_addr_i = AW'($urandom);
               cyc($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 3) < wen_lvl, a, $urandom, $urandom_range(0, 29) == 0);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
